goertzel_tone_detect: RTL

//  Downstream decision stage of the Goertzel bank. Receives one frame of NF bin powers
//  (unsigned 16.16, bin index order 0..NF-1) over a valid/ready stream. Tracks the

---
 rtl/goertzel_pkg.sv | 12 +
 rtl/goertzel_tone_detect_if.sv | 31 +++
 rtl/goertzel_tone_detect_top2.sv | 42 ++++
 rtl/goertzel_tone_detect.sv | 139 +++++++++++++
 4 files changed

// File: rtl/goertzel_pkg.sv
// Shared types and widths for the Goertzel tone-decision stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: tone_det_state_t (decision FSM states), PWR_W / PWR_FRAC (16.16 power format).
package goertzel_pkg;

  typedef enum logic [1:0] {COLLECT, DECIDE, HOLD} tone_det_state_t;

  localparam int PWR_W    = 32;
  localparam int PWR_FRAC = 16;

endpackage

// File: rtl/goertzel_tone_detect_if.sv
// Bin-power input stream plus decision output stream of the tone detector.
// Latency: n/a (wiring only).
// Backpressure: s_ready stalls the bin producer; m_ready holds a decision until it is taken.
// Ports: s_valid/s_ready/s_pwr (bin powers in), m_valid/m_ready/m_tone/m_pwr/m_hit (decision out).
// The slave modport is the detector's view; the master modport drives bins and consumes decisions.
interface goertzel_tone_detect_if
  import goertzel_pkg::*;
#(
  parameter int IW = 4
) ();

  logic             s_valid;
  logic             s_ready;
  logic [PWR_W-1:0] s_pwr;
  logic             m_valid;
  logic             m_ready;
  logic [IW-1:0]    m_tone;
  logic [PWR_W-1:0] m_pwr;
  logic             m_hit;

  modport slave (
    input  s_valid, s_pwr, m_ready,
    output s_ready, m_valid, m_tone, m_pwr, m_hit
  );

  modport master (
    output s_valid, s_pwr, m_ready,
    input  s_ready, m_valid, m_tone, m_pwr, m_hit
  );

endinterface

// File: rtl/goertzel_tone_detect_top2.sv
// Running tracker of the largest and second-largest bin power within one frame.
// Latency: 1 cycle from upd to updated best/second/best_idx.
// Backpressure: none; the caller only asserts upd on an accepted bin.
// Ports: clk, rstn, clr (sync clear, wins over upd), upd, pwr, idx -> best, second, best_idx.
module goertzel_top2
  import goertzel_pkg::*;
#(
  parameter int IW = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             upd,
  input  logic [PWR_W-1:0] pwr,
  input  logic [IW-1:0]    idx,
  output logic [PWR_W-1:0] best,
  output logic [PWR_W-1:0] second,
  output logic [IW-1:0]    best_idx
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      best     <= '0;
      second   <= '0;
      best_idx <= '0;
    end else if (clr) begin
      best     <= '0;
      second   <= '0;
      best_idx <= '0;
    end else if (upd) begin
      // Strict compares: an equal later bin never displaces the earlier index.
      if (pwr > best) begin
        second   <= best;
        best     <= pwr;
        best_idx <= idx;
      end else if (pwr > second) begin
        second <= pwr;
      end
    end
  end

endmodule

// File: rtl/goertzel_tone_detect.sv
// Per-frame tone decision: collects NF bin powers, picks the winner, applies threshold/dominance tests.
// Latency: m_valid rises on the edge after the one accepting bin NF-1 (one DECIDE cycle).
// Backpressure: s_ready is low outside COLLECT; a decision is held stable until m_ready.
// Ports: clk, rstn (async active-low), sync_clr (frame abort), thresh_i, ratio_sh_i, bus (slave modport).
// Optional macro TONE_DEBOUNCE_EN: m_hit additionally needs DB_FRAMES consecutive hits on the same bin.
module goertzel_tone_detect
  import goertzel_pkg::*;
#(
  parameter int  NF        = 11,
  parameter int  DB_FRAMES = 2,
  localparam int IW        = $clog2(NF)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  sync_clr,
  input  logic [PWR_W-1:0]      thresh_i,
  input  logic [3:0]            ratio_sh_i,
  goertzel_tone_detect_if.slave bus
);

  localparam logic [IW-1:0] LAST = IW'(NF - 1);

  tone_det_state_t  state;
  logic [IW-1:0]    cnt;
  logic [PWR_W-1:0] best, second;
  logic [IW-1:0]    best_idx;
  logic             s_ready, accept;
  logic             m_valid, m_hit;
  logic [IW-1:0]    m_tone;
  logic [PWR_W-1:0] m_pwr;
  logic             hit_raw, hit;
  logic [PWR_W+15:0] best_x, second_x;

  assign s_ready = (state == COLLECT);
  assign accept  = bus.s_valid && s_ready;

  goertzel_top2 #(.IW(IW)) u_top2 (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (sync_clr || (state == DECIDE)),
    .upd      (accept && !sync_clr),
    .pwr      (bus.s_pwr),
    .idx      (cnt),
    .best     (best),
    .second   (second),
    .best_idx (best_idx)
  );

  // 16 guard bits so second << 15 cannot overflow the dominance compare.
  assign best_x   = {16'b0, best};
  assign second_x = {16'b0, second} << ratio_sh_i;
  assign hit_raw  = (best >= thresh_i) && (best_x > second_x);

`ifdef TONE_DEBOUNCE_EN
  localparam int RW = $clog2(DB_FRAMES + 1);

  logic [IW-1:0] last_tone;
  logic [RW-1:0] run_cnt, run_cnt_next;

  always_comb begin
    run_cnt_next = '0;
    if (hit_raw) begin
      if (best_idx == last_tone)
        run_cnt_next = (run_cnt == RW'(DB_FRAMES)) ? run_cnt : run_cnt + 1'b1;
      else
        run_cnt_next = RW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_cnt   <= '0;
      last_tone <= '0;
    end else if (sync_clr) begin
      run_cnt   <= '0;
      last_tone <= '0;
    end else if (state == DECIDE) begin
      run_cnt <= run_cnt_next;
      if (hit_raw)
        last_tone <= best_idx;
    end
  end

  assign hit = hit_raw && (run_cnt_next >= RW'(DB_FRAMES));
`else
  logic unused_db;
  assign unused_db = (DB_FRAMES != 0);
  assign hit       = hit_raw;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= COLLECT;
      cnt     <= '0;
      m_valid <= 1'b0;
      m_tone  <= '0;
      m_pwr   <= '0;
      m_hit   <= 1'b0;
    end else if (sync_clr) begin
      // Abort wins over any handshake in the same cycle; a held decision is dropped.
      state   <= COLLECT;
      cnt     <= '0;
      m_valid <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            if (cnt == LAST)
              state <= DECIDE;
            else
              cnt <= cnt + 1'b1;
          end
        end
        DECIDE: begin
          cnt     <= '0;
          m_tone  <= best_idx;
          m_pwr   <= best;
          m_hit   <= hit;
          m_valid <= 1'b1;
          state   <= HOLD;
        end
        HOLD: begin
          if (m_valid && bus.m_ready) begin
            m_valid <= 1'b0;
            state   <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign bus.s_ready = s_ready;
  assign bus.m_valid = m_valid;
  assign bus.m_tone  = m_tone;
  assign bus.m_pwr   = m_pwr;
  assign bus.m_hit   = m_hit;

endmodule
